neuron_seq_mac: RTL
===================

# neuron_seq_mac

Time-multiplexed, parametrised hidden/output-layer neuron for the mine-detection network. One shared sign-magnitude multiplier walks the `N_IN` inputs serially, one per cycle, in place of one multiplier per input. Products go into separate positive and negative magnitude accumulators. Weights and a bias are runtime-writable rather than hard-wired. The resolved sign/magnitude sum feeds the existing `Sigmoid_LUT` to produce a 16-bit probability, with a start/done handshake toward the layer controller.

## Interface
- `N_IN`, 60: number of inputs (≥2).
- `ACC_W`, 22: accumulator and suma width; must match `Sigmoid_LUT.suma`.
- `ADDR_W`, 6: weight address width; 2^ADDR_W ≥ N_IN+1.
- `clk` in 1: clock. Single clock domain; everything is on the rising edge.
- `rst` in 1: reset. Synchronous and active-high.
- `start` in 1: request an evaluation. Sampled only in IDLE.
- `uzorak` in N_IN*16: inputs, sign-magnitude. Input k is at bits `[16k+15:16k]`. Captured on the start cycle.
- `wr_en` in 1: weight/bias write strobe. Honoured only in IDLE.
- `wr_addr` in ADDR_W: 0..N_IN-1 selects a weight; N_IN selects the bias.
- `wr_data` in 16: sign-magnitude value. Bit15 is the sign (1 = negative); bits 14:0 are the magnitude.
- `busy` out 1: evaluation in progress.
- `done` out 1: one-cycle pulse when `izlaz` is updated.
- `izlaz` out 16: sigmoid output. Holds its value between evaluations.

## Operation
- FSM: IDLE → MAC → RESOLVE → OUT → IDLE.
- **IDLE**
  - `start`=1 latches `uzorak` and sets idx=0.
  - Preloads the accumulators from the bias: sign 0 loads P=bias magnitude, N=0; sign 1 loads N=bias magnitude, P=0.
  - Goes to MAC.
- **MAC**, one term per cycle:
  - term = `mnozenje`(weight[idx] with bit15 cleared, sample[idx] with bit15 cleared). The 16-bit result is a magnitude.
  - sign = weight[idx][15] XOR sample[idx][15].
  - sign 0 adds the term to P; sign 1 adds it to N.
  - P and N are zero-extended to ACC_W and saturate at 2^ACC_W−1; they never wrap.
  - After idx=N_IN−1, go to RESOLVE.
- **RESOLVE**
  - P>N: suma=P−N, predznak=0.
  - Otherwise (including P==N): suma=N−P, predznak=1.
  - Both are registered.
- **OUT**
  - `izlaz` ← `Sigmoid_LUT`(suma, predznak).
  - `done`=1 for this cycle.
  - Return to IDLE.
- Writes:
  - `wr_en` in IDLE writes the addressed entry.
  - Addresses > N_IN are ignored.
  - Writes outside IDLE are dropped silently.
  - If `start` and `wr_en` are asserted in the same IDLE cycle, the write happens first. The written value takes effect in this evaluation: for the bias, in the preload; for a weight, in its MAC term.
- `start` while `busy` is ignored; it is not queued.

## Timing
- Start sampled at edge 0. MAC terms are accumulated at edges 1..N_IN. RESOLVE registers at edge N_IN+1. `izlaz` and `done` are updated at edge N_IN+2.
- Latency from start to `done` is N_IN+2 cycles.
- `busy`=1 from after edge 0 until edge N_IN+2.
- `done`=1 and `busy`=0 in the same cycle. A new `start` is accepted in that cycle, giving a throughput of one result per N_IN+2 cycles.
- Reset values: `izlaz`=0, `done`=0, `busy`=0, state=IDLE, P=N=0, suma=0, predznak=0, idx=0.
- The weight bank and bias are not reset, so preloaded values survive a reset.
- `rst` mid-evaluation returns to IDLE at the next edge. No `done` is produced, and `izlaz` is cleared to 0.
- `uzorak` may change freely after the start cycle.

## Structure
- Shared package `neuron_pkg` holds:
  - `SM_W`=16, `SIGN_BIT`=15.
  - Default `ACC_W`.
  - The FSM state enum.
  - A sign-magnitude word typedef.
- Sub-module `neuron_weight_bank`: (N_IN+1)×16 register file with one write port and two combinational read ports (weight[idx], bias), no reset.
- Existing `mnozenje` is instantiated once and `Sigmoid_LUT` once.

## Test plan
Benches run at N_IN=4 unless stated.
- **All positive, no saturation.** Weights 0x1000 each, bias 0, all samples 0x1000. Start once. Required:
  - `done` exactly 6 cycles after start, `busy` high 6 cycles.
  - predznak=0, suma = 4×`mnozenje`(0x1000, 0x1000).
  - `izlaz` equals the LUT value for those inputs.
- **Exact cancellation.** Weights alternate 0x1000/0x9000, samples all 0x1000, bias 0. Required: suma=0, predznak=1 (tie case).
- **Saturation.** ACC_W=16, all weights and samples at maximum magnitude. Required: P holds 0xFFFF with no wrap; suma=0xFFFF, predznak=0.
- **Bias only.** All weights 0, bias written as 0x8123 in the same cycle as start. Required: suma=0x0123, predznak=1.
- **Protocol.**
  - `start` and `wr_en` pulsed at cycle 2 of busy: both are ignored, no second `done`, weight unchanged.
  - Back-to-back start in the `done` cycle: second `done` arrives 6 cycles later.
- **Reset.** `rst` at MAC cycle 2. Required:
  - Next cycle busy=0, izlaz=0, no `done`.
  - A following start with the same weights still produces the correct result, showing the weights were retained.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and constants for the time-multiplexed sign-magnitude neuron.
package neuron_pkg;

  localparam int unsigned SM_W          = 16;
  localparam int unsigned SIGN_BIT      = 15;
  localparam int unsigned ACC_W_DEFAULT = 22;

  typedef logic [SM_W-1:0] sm_word_t;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StResolve,
    StOut
  } state_e;

  // Strip the sign bit, leaving a 16-bit magnitude.
  function automatic sm_word_t sm_mag(input sm_word_t w);
    return {1'b0, w[SIGN_BIT-1:0]};
  endfunction

endpackage

// File: rtl/Sigmoid_LUT.sv
// Hard-sigmoid approximation: 0.5 + x/4 in Q0.16, x in Q.12, clamped to 1..0xFFFF.
module Sigmoid_LUT #(
  parameter int unsigned ACC_W = 22
) (
  input  logic [ACC_W-1:0] suma,
  input  logic             predznak,
  output logic [15:0]      izlaz
);

  logic [ACC_W+1:0] scaled;
  logic [14:0]      delta;

  always_comb begin
    scaled = {suma, 2'b00};
    delta  = (|scaled[ACC_W+1:15]) ? 15'h7FFF : scaled[14:0];
    izlaz  = predznak ? (16'h8000 - {1'b0, delta}) : (16'h8000 + {1'b0, delta});
  end

endmodule

// File: rtl/mnozenje.sv
// Sign-magnitude Q3.12 multiplier; the magnitude saturates at 0x7FFF.
module mnozenje
  import neuron_pkg::*;
(
  input  sm_word_t a,
  input  sm_word_t b,
  output sm_word_t rezultat
);

  logic [29:0] prod;
  logic [29:0] prod_sh;

  always_comb begin
    prod     = 30'(a[SIGN_BIT-1:0]) * 30'(b[SIGN_BIT-1:0]);
    prod_sh  = prod >> 12;
    rezultat = {a[SIGN_BIT] ^ b[SIGN_BIT],
                (|prod_sh[29:15]) ? 15'h7FFF : prod_sh[14:0]};
  end

endmodule

// File: rtl/neuron_weight_bank.sv
// (N_IN+1)x16 weight/bias register file: one write port, weight and bias read ports, no reset.
module neuron_weight_bank
  import neuron_pkg::*;
#(
  parameter int unsigned N_IN   = 60,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned IDX_W  = $clog2(N_IN + 1)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  sm_word_t          wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output sm_word_t          rd_data,
  output sm_word_t          bias
);

  localparam logic [ADDR_W-1:0] BIAS_ADDR = ADDR_W'(N_IN);

  sm_word_t mem_q [N_IN+1];

  always_ff @(posedge clk) begin
    if (we && (wr_addr <= BIAS_ADDR)) begin
      mem_q[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];
  assign bias    = mem_q[N_IN];

endmodule

// File: rtl/neuron_seq_mac.sv
// Serial MAC neuron: one shared multiplier, split P/N magnitude accumulators, sigmoid output.
module neuron_seq_mac
  import neuron_pkg::*;
#(
  parameter int unsigned N_IN   = 60,
  parameter int unsigned ACC_W  = ACC_W_DEFAULT,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_IN*SM_W-1:0] uzorak,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  sm_word_t             wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          izlaz
);

  localparam int unsigned       IDX_W     = $clog2(N_IN + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_IN - 1);
  localparam logic [ADDR_W-1:0] BIAS_ADDR = ADDR_W'(N_IN);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ACC_W-1:0]      p_q, p_d, n_q, n_d;
  logic [ACC_W-1:0]      suma_q, suma_d;
  logic                  predznak_q, predznak_d;
  logic [15:0]           izlaz_q, izlaz_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [N_IN*SM_W-1:0]  smp_q, smp_d;

  logic                  bank_we;
  sm_word_t              weight, bias_rd, bias_eff, prod;
  logic                  term_neg;
  logic [ACC_W:0]        acc_sum;
  logic [ACC_W-1:0]      acc_sat;
  logic [15:0]           lut_izlaz;

  assign bank_we = wr_en && (state_q == StIdle);

  neuron_weight_bank #(
    .N_IN   (N_IN),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_bank (
    .clk     (clk),
    .we      (bank_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_idx  (idx_q),
    .rd_data (weight),
    .bias    (bias_rd)
  );

  // The current sample always sits in the low word; the register shifts right per term.
  mnozenje u_mul (
    .a        (sm_mag(weight)),
    .b        (sm_mag(smp_q[SM_W-1:0])),
    .rezultat (prod)
  );

  Sigmoid_LUT #(
    .ACC_W (ACC_W)
  ) u_lut (
    .suma     (suma_q),
    .predznak (predznak_q),
    .izlaz    (lut_izlaz)
  );

  always_comb begin
    // A bias write in the start cycle must already be visible to the preload.
    bias_eff = (bank_we && (wr_addr == BIAS_ADDR)) ? wr_data : bias_rd;
    term_neg = weight[SIGN_BIT] ^ smp_q[SIGN_BIT];
    acc_sum  = {1'b0, (term_neg ? n_q : p_q)} + (ACC_W+1)'(prod);
    acc_sat  = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    p_d        = p_q;
    n_d        = n_q;
    suma_d     = suma_q;
    predznak_d = predznak_q;
    izlaz_d    = izlaz_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    smp_d      = smp_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          smp_d   = uzorak;
          idx_d   = '0;
          p_d     = bias_eff[SIGN_BIT] ? '0 : ACC_W'(bias_eff[SIGN_BIT-1:0]);
          n_d     = bias_eff[SIGN_BIT] ? ACC_W'(bias_eff[SIGN_BIT-1:0]) : '0;
          busy_d  = 1'b1;
          state_d = StMac;
        end
      end
      StMac: begin
        if (term_neg) begin
          n_d = acc_sat;
        end else begin
          p_d = acc_sat;
        end
        smp_d = {{SM_W{1'b0}}, smp_q[N_IN*SM_W-1:SM_W]};
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = StResolve;
        end
      end
      StResolve: begin
        if (p_q > n_q) begin
          suma_d     = p_q - n_q;
          predznak_d = 1'b0;
        end else begin
          suma_d     = n_q - p_q;
          predznak_d = 1'b1;
        end
        state_d = StOut;
      end
      StOut: begin
        izlaz_d = lut_izlaz;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      p_q        <= '0;
      n_q        <= '0;
      suma_q     <= '0;
      predznak_q <= 1'b0;
      izlaz_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      smp_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      p_q        <= p_d;
      n_q        <= n_d;
      suma_q     <= suma_d;
      predznak_q <= predznak_d;
      izlaz_q    <= izlaz_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      smp_q      <= smp_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign izlaz = izlaz_q;

endmodule
